// File: rtl/int_arbiter.sv
// Multi-source interrupt arbiter: rising-edge capture into pending flags, software
// enable mask and acknowledge over the IO port bus, fixed-length INTERRUPT pulse.
module int_arbiter #(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned PULSE_LEN    = 6,
  parameter logic [7:0]  MASK_PORT_ID = 8'h20,
  parameter logic [7:0]  ACK_PORT_ID  = 8'h21,
  parameter int unsigned ID_W         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] REQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic             INTERRUPT,
  output logic [ID_W-1:0]  INT_ID,
  output logic [N_SRC-1:0] PENDING,
  output logic [N_SRC-1:0] MASK
);

  localparam int unsigned CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [N_SRC-1:0] r_req_d;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_int_id;
  logic             r_irq;

  logic [N_SRC-1:0] w_rise;
  logic             w_mask_wr;
  logic             w_ack_wr;
  logic [N_SRC-1:0] w_ack_clr;
  logic [N_SRC-1:0] w_eligible;
  logic [ID_W-1:0]  w_pick;
  logic             w_cur_pend;
  logic             w_cur_en;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ID_W-1:0]  w_id_nxt;
  logic             w_irq_nxt;
  logic             w_unused_out;

  // Upper OUT_PORT bits beyond N_SRC carry no meaning for this block.
  assign w_unused_out = ^OUT_PORT;

  assign w_rise     = REQ & ~r_req_d;
  assign w_mask_wr  = IO_STRB && (PORT_ID == MASK_PORT_ID);
  assign w_ack_wr   = IO_STRB && (PORT_ID == ACK_PORT_ID);
  assign w_ack_clr  = w_ack_wr ? OUT_PORT[N_SRC-1:0] : '0;
  assign w_eligible = r_pending & r_mask;
  assign w_cur_pend = r_pending[r_int_id];
  assign w_cur_en   = r_mask[r_int_id];

  // Lowest enabled pending index wins.
  always_comb begin
    w_pick = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_pick = ID_W'(i);
    end
  end

  // Edge capture, pending flags (set beats clear) and mask register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_req_d   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_req_d   <= REQ;
      r_pending <= (r_pending & ~w_ack_clr) | w_rise;
      if (w_mask_wr) r_mask <= OUT_PORT[N_SRC-1:0];
    end
  end

  // State register; INTERRUPT is registered from the next-state decode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_int_id <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_int_id <= w_id_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_int_id;
    w_irq_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt = S_PULSE;
          w_id_nxt    = w_pick;
          w_cnt_nxt   = '0;
          w_irq_nxt   = 1'b1;
        end
      end
      S_PULSE: begin
        if (r_cnt == CNT_W'(PULSE_LEN - 1)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_irq_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (!w_cur_pend || !w_cur_en) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign INTERRUPT = r_irq;
  assign INT_ID    = r_int_id;
  assign PENDING   = r_pending;
  assign MASK      = r_mask;

endmodule
